// File: rtl/router_sync_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | router_sync_n: NUM_CH-way write steering, full mux, read-timeout watchdog |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module router_sync_n #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic              sts_clr,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] valid_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err,
  output logic [NUM_CH-1:0] timeout_sts
);

  localparam int            CNT_W    = $clog2(TIMEOUT);
  localparam logic [ADDR_W:0] C_NUM_CH = (ADDR_W+1)'(NUM_CH);
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(TIMEOUT - 1);

  logic [ADDR_W-1:0]             dest_q, dest_d;
  logic                          dest_vld_q, dest_vld_d;
  logic                          addr_err_q, addr_err_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0]             soft_reset_q, soft_reset_d;
  logic [NUM_CH-1:0]             sts_q, sts_d;
  logic [NUM_CH-1:0]             w_sel;
  logic                          w_in_range;

  // Widened compare so NUM_CH == 2**ADDR_W is handled without overflow.
  assign w_in_range = ({1'b0, data_in} < C_NUM_CH);

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_chan
      assign w_sel[g] = dest_vld_q & (dest_q == ADDR_W'(g));
    end
  endgenerate

  assign write_enb   = w_sel & {NUM_CH{write_enb_reg}};
  assign fifo_full   = |(w_sel & full);
  assign valid_out   = ~empty;
  assign soft_reset  = soft_reset_q;
  assign addr_err    = addr_err_q;
  assign timeout_sts = sts_q;

  always_comb begin
    dest_d       = dest_q;
    dest_vld_d   = dest_vld_q;
    addr_err_d   = 1'b0;
    cnt_d        = cnt_q;
    soft_reset_d = '0;
    sts_d        = sts_clr ? '0 : sts_q;
    if (detect_add) begin
      dest_d     = data_in;
      dest_vld_d = w_in_range;
      addr_err_d = ~w_in_range;
    end
    // A timeout setting its status bit overrides a same-cycle clear.
    for (int i = 0; i < NUM_CH; i++) begin
      if (empty[i] || read_enb[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == C_LAST) begin
        cnt_d[i]        = '0;
        soft_reset_d[i] = 1'b1;
        sts_d[i]        = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dest_q       <= '0;
      dest_vld_q   <= 1'b0;
      addr_err_q   <= 1'b0;
      cnt_q        <= '0;
      soft_reset_q <= '0;
      sts_q        <= '0;
    end else begin
      dest_q       <= dest_d;
      dest_vld_q   <= dest_vld_d;
      addr_err_q   <= addr_err_d;
      cnt_q        <= cnt_d;
      soft_reset_q <= soft_reset_d;
      sts_q        <= sts_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_router_sync_n.sv
`default_nettype none
// Directed testbench for router_sync_n (NUM_CH=3, ADDR_W=2, TIMEOUT=30).
module tb_router_sync_n;

  localparam int NUM_CH  = 3;
  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 30;

  logic              clk = 1'b0;
  logic              reset;
  logic              detect_add;
  logic [ADDR_W-1:0] data_in;
  logic              write_enb_reg;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] read_enb;
  logic              sts_clr;
  logic [NUM_CH-1:0] write_enb;
  logic              fifo_full;
  logic [NUM_CH-1:0] valid_out;
  logic [NUM_CH-1:0] soft_reset;
  logic              addr_err;
  logic [NUM_CH-1:0] timeout_sts;

  int checks = 0;
  int errors = 0;

  router_sync_n #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg), .full(full), .empty(empty),
    .read_enb(read_enb), .sts_clr(sts_clr), .write_enb(write_enb),
    .fifo_full(fifo_full), .valid_out(valid_out), .soft_reset(soft_reset),
    .addr_err(addr_err), .timeout_sts(timeout_sts)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: sim still running, required to finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; detect_add = 1'b0; data_in = '0; write_enb_reg = 1'b0;
    full = '0; empty = '1; read_enb = '0; sts_clr = 1'b0;
    tick(); tick();
    checks++; if (soft_reset !== 3'b000) begin errors++; $display("FAIL rst_soft_reset: got %b want 000", soft_reset); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL rst_addr_err: got %b want 0", addr_err); end
    checks++; if (timeout_sts !== 3'b000) begin errors++; $display("FAIL rst_timeout_sts: got %b want 000", timeout_sts); end
    checks++; if (valid_out !== 3'b000) begin errors++; $display("FAIL rst_valid_out: got %b want 000", valid_out); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_addr_latch();
    write_enb_reg = 1'b1; full = 3'b100;
    #1;
    checks++; if (write_enb !== 3'b000) begin errors++; $display("FAIL latch_no_dest_we: got %b want 000", write_enb); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL latch_no_dest_full: got %b want 0", fifo_full); end
    detect_add = 1'b1; data_in = 2'd2;
    #1;
    checks++; if (write_enb !== 3'b000) begin errors++; $display("FAIL latch_same_cycle_we: got %b want 000", write_enb); end
    tick();
    detect_add = 1'b0;
    #1;
    checks++; if (write_enb !== 3'b100) begin errors++; $display("FAIL latch_dest2_we: got %b want 100", write_enb); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL latch_dest2_full: got %b want 1", fifo_full); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL latch_addr_err: got %b want 0", addr_err); end
  endtask

  task automatic test_addr_err();
    detect_add = 1'b1; data_in = 2'd3;
    #1;
    checks++; if (write_enb !== 3'b100) begin errors++; $display("FAIL err_old_dest_we: got %b want 100", write_enb); end
    tick();
    detect_add = 1'b0;
    #1;
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b want 1", addr_err); end
    checks++; if (write_enb !== 3'b000) begin errors++; $display("FAIL err_we: got %b want 000", write_enb); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL err_full: got %b want 0", fifo_full); end
    tick();
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b want 0", addr_err); end
    detect_add = 1'b1; data_in = 2'd1; full = 3'b010;
    tick();
    detect_add = 1'b0;
    #1;
    checks++; if (write_enb !== 3'b010) begin errors++; $display("FAIL err_dest1_we: got %b want 010", write_enb); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL err_dest1_full: got %b want 1", fifo_full); end
    write_enb_reg = 1'b0;
  endtask

  task automatic test_timeout();
    empty = 3'b110;
    #1;
    checks++; if (valid_out !== 3'b001) begin errors++; $display("FAIL to_valid_out: got %b want 001", valid_out); end
    repeat (TIMEOUT - 1) tick();
    checks++; if (soft_reset !== 3'b000) begin errors++; $display("FAIL to_edge29: got %b want 000", soft_reset); end
    tick();
    checks++; if (soft_reset !== 3'b001) begin errors++; $display("FAIL to_edge30: got %b want 001", soft_reset); end
    checks++; if (timeout_sts !== 3'b001) begin errors++; $display("FAIL to_sts: got %b want 001", timeout_sts); end
    tick();
    checks++; if (soft_reset !== 3'b000) begin errors++; $display("FAIL to_edge31: got %b want 000", soft_reset); end
    repeat (TIMEOUT - 2) tick();
    checks++; if (soft_reset !== 3'b000) begin errors++; $display("FAIL to_edge59: got %b want 000", soft_reset); end
    tick();
    checks++; if (soft_reset !== 3'b001) begin errors++; $display("FAIL to_edge60: got %b want 001", soft_reset); end
    empty = '1;
    tick();
  endtask

  task automatic test_read_restart();
    empty = 3'b110;
    repeat (TIMEOUT - 2) tick();
    read_enb = 3'b001;
    tick();
    checks++; if (soft_reset !== 3'b000) begin errors++; $display("FAIL rd_edge29: got %b want 000", soft_reset); end
    read_enb = 3'b000;
    tick();
    checks++; if (soft_reset !== 3'b000) begin errors++; $display("FAIL rd_edge30: got %b want 000", soft_reset); end
    repeat (TIMEOUT - 2) tick();
    checks++; if (soft_reset !== 3'b000) begin errors++; $display("FAIL rd_edge58: got %b want 000", soft_reset); end
    tick();
    checks++; if (soft_reset !== 3'b001) begin errors++; $display("FAIL rd_edge59: got %b want 001", soft_reset); end
    empty = '1;
    tick();
  endtask

  task automatic test_independent();
    empty = 3'b101;
    repeat (5) tick();
    empty = 3'b001;
    repeat (TIMEOUT - 6) tick();
    checks++; if (soft_reset !== 3'b000) begin errors++; $display("FAIL ind_edge29: got %b want 000", soft_reset); end
    tick();
    checks++; if (soft_reset !== 3'b010) begin errors++; $display("FAIL ind_ch1_pulse: got %b want 010", soft_reset); end
    checks++; if (timeout_sts !== 3'b011) begin errors++; $display("FAIL ind_sts_ch1: got %b want 011", timeout_sts); end
    repeat (4) tick();
    checks++; if (soft_reset !== 3'b000) begin errors++; $display("FAIL ind_edge34: got %b want 000", soft_reset); end
    sts_clr = 1'b1;
    tick();
    sts_clr = 1'b0;
    checks++; if (soft_reset !== 3'b100) begin errors++; $display("FAIL ind_ch2_pulse: got %b want 100", soft_reset); end
    checks++; if (timeout_sts !== 3'b100) begin errors++; $display("FAIL ind_sts_clr: got %b want 100", timeout_sts); end
    empty = '1;
    tick();
  endtask

  task automatic test_async_reset();
    empty = 3'b110; full = 3'b111; write_enb_reg = 1'b1;
    repeat (20) tick();
    #3;
    reset = 1'b1;
    #1;
    checks++; if (timeout_sts !== 3'b000) begin errors++; $display("FAIL ar_sts: got %b want 000", timeout_sts); end
    checks++; if (soft_reset !== 3'b000) begin errors++; $display("FAIL ar_soft: got %b want 000", soft_reset); end
    checks++; if (write_enb !== 3'b000) begin errors++; $display("FAIL ar_we: got %b want 000", write_enb); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL ar_full: got %b want 0", fifo_full); end
    tick();
    reset = 1'b0;
    repeat (TIMEOUT - 1) tick();
    checks++; if (soft_reset !== 3'b000) begin errors++; $display("FAIL ar_edge29: got %b want 000", soft_reset); end
    tick();
    checks++; if (soft_reset !== 3'b001) begin errors++; $display("FAIL ar_edge30: got %b want 001", soft_reset); end
    empty = '1; write_enb_reg = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_addr_latch();
    test_addr_err();
    test_timeout();
    test_read_restart();
    test_independent();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/router_sync_n.md
Name: router_sync_n

Overview:
Parametrised successor of the 1x3 router synchroniser. It supports NUM_CH output FIFOs and routes the FSM write strobe to the FIFO selected by the latched header address. It muxes back that FIFO's full flag and generates per-channel valid_out. It also runs per-channel read-timeout watchdogs that issue single-cycle soft resets and latch sticky timeout status. It sits between the router FSM/register block and the NUM_CH output FIFOs.

Parameters:
NUM_CH, 3, number of output channels/FIFOs; 1 <= NUM_CH <= 2**ADDR_W.
ADDR_W, 2, width of the header address field on data_in.
TIMEOUT, 30, consecutive unread-valid cycles before soft reset; >= 2. Counter width is derived as clog2(TIMEOUT).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
detect_add  in  1  header-address strobe from FSM
data_in  in  ADDR_W  destination address (header low bits)
write_enb_reg  in  1  write request from FSM
full  in  NUM_CH  per-FIFO full flags
empty  in  NUM_CH  per-FIFO empty flags
read_enb  in  NUM_CH  per-channel read enables from destination
sts_clr  in  1  clears timeout_sts (pulse)
write_enb  out  NUM_CH  one-hot FIFO write enables
fifo_full  out  1  full flag of the selected FIFO
valid_out  out  NUM_CH  per-channel data-available
soft_reset  out  NUM_CH  per-FIFO soft-reset pulse
addr_err  out  1  out-of-range address pulse
timeout_sts  out  NUM_CH  sticky per-channel timeout record

Behaviour:
- Reset (async assert, sync release): dest=0, dest_vld=0, all counters=0, soft_reset=0, addr_err=0, timeout_sts=0.
- Address latch: on a clk edge with detect_add=1, dest<=data_in and dest_vld<=(data_in<NUM_CH). Otherwise both hold. A new detect_add overwrites a previous one.
- addr_err: registered. It is 1 for exactly the cycle after an edge where detect_add=1 and data_in>=NUM_CH, else 0.
- write_enb[i] (combinational): write_enb_reg & dest_vld & (dest==i). At most one bit is set. When detect_add and write_enb_reg are high in the same cycle, the previously latched dest is used.
- fifo_full (combinational): dest_vld ? full[dest] : 0. It is 0 after reset until the first valid address.
- valid_out[i] = ~empty[i], combinational, no latency.
- Watchdog per channel i, evaluated each edge:
  - If empty[i]=1 or read_enb[i]=1: cnt<=0, soft_reset[i]<=0.
  - Else if cnt==TIMEOUT-1: soft_reset[i]<=1, cnt<=0.
  - Else: cnt<=cnt+1, soft_reset[i]<=0.
- Watchdog timing: soft_reset[i] goes high in the cycle after the TIMEOUT-th consecutive edge that sampled valid_out[i]=1 and read_enb[i]=0. It lasts exactly one cycle, then counting restarts from 0. It pulses again after another TIMEOUT cycles if the channel is still unread. Channels are fully independent.
- A read_enb pulse at any count returns cnt to 0; no soft reset is issued.
- timeout_sts[i] is set in the same edge soft_reset[i] is set. sts_clr clears all bits. Set wins over a simultaneous sts_clr for that bit.
- Reset asserted mid-count or mid-pulse clears everything immediately (async). No pending pulse is emitted after release.
- write_enb, fifo_full and valid_out have no registered latency. soft_reset, addr_err and timeout_sts are registered outputs.

Test Plan:
- Reset, then write_enb_reg=1 with no detect_add -> write_enb=000, fifo_full=0. Then detect_add with data_in=2 and full=100 -> next cycle write_enb=100, fifo_full=1.
- detect_add data_in=3 (NUM_CH=3) -> addr_err=1 for one cycle, write_enb=000 while write_enb_reg=1, fifo_full=0. Then detect_add data_in=1 -> write_enb=010.
- empty[0]=0, read_enb[0]=0 held for 30 edges -> soft_reset[0]=1 for one cycle exactly after the 30th edge, timeout_sts[0]=1. Held 30 more edges -> second pulse.
- Same as above but read_enb[0]=1 at edge 29 -> no soft_reset. The count restarts, and the pulse comes 30 edges after the read.
- Channels 1 and 2 unread, starting 5 cycles apart -> independent pulses 5 cycles apart. sts_clr in the same cycle as the second pulse -> timeout_sts=100 afterwards.
- Assert reset asynchronously at count 20 -> all outputs 0 immediately. After release, a full 30 cycles are needed before the next soft_reset.
